mem_fetch_sequencer: RTL and testbench
======================================

# mem_fetch_sequencer

Address-generation and read-sequencing controller for the 32K x 32-bit main memory in the MNIST accelerator. For one dense layer it walks the output neurons in groups of 10 and, per group, issues one bias read and then `in_len` input/weight reads on the memory's x, w1..w10 and b1..b10 address pointers. It emits data-valid tags aligned to the memory's one-cycle registered read data, so the 10-lane MAC array can consume the data directly. It sits between the top-level layer control and `main_memory_32k_x_32bit`, and it never writes memory.

## Interface
- `LANES`, 10: neurons per group. Fixed; matches the memory's 10 w/b ports.
- `AW`, 16: address width.
- `clock_mem` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse. Sampled only in IDLE.
- `cfg_x_base`, `cfg_w_base`, `cfg_b_base` in AW each: base addresses. Sampled at `start`.
- `cfg_in_len` in AW: inputs per neuron. Sampled at `start`.
- `cfg_out_len` in AW: neurons in the layer. Sampled at `start`.
- `acc_ready` in 1: the MAC array can accept. Low means stall.
- `mem_rd_en` out 1: connects to the memory's `rd_en`.
- `x_addr` out AW: memory pointer.
- `w1_addr`..`w10_addr` out AW each: memory pointers.
- `b1_addr`..`b10_addr` out AW each: memory pointers.
- `bias_valid` out 1: memory b*_data is valid this cycle.
- `data_valid` out 1: memory x/w*_data is valid this cycle.
- `last_valid` out 1: accompanies the final `data_valid` of a group.
- `lane_mask` out 10: bit k-1 set means lane k holds a real neuron in the current group.
- `group_idx` out AW: index of the current group.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of layer.
- `cfg_err` out 1: one-cycle pulse when the configuration is rejected.

## Operation
- **States:** IDLE, INIT, BIAS, STREAM, NEXT, DONE.
- **IDLE:** on `start`, latch the configuration.
  - If `cfg_in_len==0` or `cfg_out_len==0`, go to DONE and assert `cfg_err` alongside `done`. No reads are issued.
  - Otherwise go to INIT.
- **INIT** (1 cycle):
  - Set `row[k] = w_base + k*in_len` for k=0..9.
  - Set `nbase = 0`, `group_idx = 0`, `i = 0`.
- **BIAS:**
  - Drive `b(k+1)_addr = b_base + nbase + k`.
  - When `acc_ready` is high: `mem_rd_en=1`, go to STREAM.
  - When `acc_ready` is low: `mem_rd_en=0`, hold state.
- **STREAM:**
  - Drive `x_addr = x_base + i` and `w(k+1)_addr = row[k] + i`.
  - Each cycle with `acc_ready` high: `mem_rd_en=1`, `i++`.
  - When `i==in_len-1` is issued, go to NEXT.
  - `acc_ready` low: `mem_rd_en=0`; addresses and `i` hold.
- **NEXT** (1 cycle, `mem_rd_en=0`):
  - Update `row[k] += LANES*in_len`, `nbase += LANES`, `group_idx++`, `i = 0`.
  - If `nbase + LANES >= out_len`, go to DONE; otherwise go to BIAS.
- **DONE** (1 cycle): `done=1`, then IDLE.
- **lane_mask:** bit k is set iff `nbase + k < out_len`. The final group may be partial.
  - Masked lanes are still addressed and read.
  - The consumer discards masked lanes.
- **Arithmetic:** all address math is modulo 2^AW (truncate, no saturation, no error). `k*in_len` and `LANES*in_len` are truncated to AW.
- **Ignored input:** `start` outside IDLE has no effect.
- **Reset** (`rst==0` at an edge), from any state including mid-stream:
  - State goes to IDLE.
  - Outputs reset as follows: `mem_rd_en`, `bias_valid`, `data_valid`, `last_valid`, `busy`, `done`, `cfg_err` = 0; all addresses = 0; `lane_mask` = 0; `group_idx` = 0.
  - Latched configuration is cleared.
  - Any in-flight read tag is dropped.

## Timing
- **Outputs:** addresses and `mem_rd_en` are combinational from registered state. Memory data is available one cycle after the `mem_rd_en` edge.
- **Valid flags:**
  - `bias_valid(t+1) = mem_rd_en(t)` when in BIAS.
  - `data_valid(t+1) = mem_rd_en(t)` when in STREAM.
  - `last_valid(t+1)` = the same condition plus `i==in_len-1`.
  - Each flag is a registered single pulse per issued read. It is not repeated during a stall, even though the memory holds its output.
- **Stall-free group cost:** 1 (BIAS) + `in_len` (STREAM) + 1 (NEXT) cycles.
- **Layer latency:** `start` at cycle 0 leads to INIT at cycle 1 and the first BIAS at cycle 2. `done` is at cycle `2 + G*(in_len+2)`, where `G = ceil(out_len/10)`.
- **Rejected config:** `start` at cycle 0 gives `done` and `cfg_err` at cycle 1.
- **Restart:** `busy` is high from cycle 1 until `done` inclusive. `start` is accepted again the cycle after `done`.

## Test plan
- **Single group, no stalls:** `in_len=4`, `out_len=10`, `x_base=0x0000`, `w_base=0x0100`, `b_base=0x0080` →
  - BIAS reads b1..b10 at 0x80..0x89.
  - Four reads: `x_addr` 0..3, `w3_addr` 0x108..0x10B.
  - 4 `data_valid` pulses, with `last_valid` on the 4th.
  - `done` at cycle 8; `lane_mask=0x3FF`.
- **Partial final group:** `in_len=2`, `out_len=13`, `w_base=0x0200` →
  - 2 groups; group 1 `w1_addr` starts 0x214; `lane_mask=0x007`; `group_idx=1`.
  - `done` at cycle 10.
- **Stall:** `in_len=4`, `acc_ready` low for 3 cycles after the second STREAM read →
  - Addresses frozen during the stall; exactly 4 `data_valid` pulses.
  - `done` is delayed by 3 cycles.
- **Reset mid-stream:** `rst=0` during STREAM `i=2` →
  - Next cycle: IDLE, all outputs 0, no further valid pulses.
  - A fresh `start` then runs normally.
- **Bad config:** `cfg_in_len=0` → `done` and `cfg_err` at cycle 1, `mem_rd_en` never asserted. The same holds for `cfg_out_len=0`.
- **Busy start and wrap:** a second `start` during BIAS is ignored (only 1 `done`). `w_base=0xFFFE`, `in_len=4` → `w1_addr` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/mem_fetch_sequencer.sv
// mem_fetch_sequencer
// Walks one dense layer in groups of 10 output neurons. Each group issues one
// bias read followed by in_len input/weight reads on the main memory's x,
// w1..w10 and b1..b10 pointers. It also emits valid tags aligned to the
// memory's one-cycle registered read data. The block only reads memory.

module mem_fetch_sequencer #(
    parameter int AW = 16
) (
    input  logic          clock_mem,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] cfg_x_base,
    input  logic [AW-1:0] cfg_w_base,
    input  logic [AW-1:0] cfg_b_base,
    input  logic [AW-1:0] cfg_in_len,
    input  logic [AW-1:0] cfg_out_len,
    input  logic          acc_ready,
    output logic          mem_rd_en,
    output logic [AW-1:0] x_addr,
    output logic [AW-1:0] w1_addr,
    output logic [AW-1:0] w2_addr,
    output logic [AW-1:0] w3_addr,
    output logic [AW-1:0] w4_addr,
    output logic [AW-1:0] w5_addr,
    output logic [AW-1:0] w6_addr,
    output logic [AW-1:0] w7_addr,
    output logic [AW-1:0] w8_addr,
    output logic [AW-1:0] w9_addr,
    output logic [AW-1:0] w10_addr,
    output logic [AW-1:0] b1_addr,
    output logic [AW-1:0] b2_addr,
    output logic [AW-1:0] b3_addr,
    output logic [AW-1:0] b4_addr,
    output logic [AW-1:0] b5_addr,
    output logic [AW-1:0] b6_addr,
    output logic [AW-1:0] b7_addr,
    output logic [AW-1:0] b8_addr,
    output logic [AW-1:0] b9_addr,
    output logic [AW-1:0] b10_addr,
    output logic          bias_valid,
    output logic          data_valid,
    output logic          last_valid,
    output logic [9:0]    lane_mask,
    output logic [AW-1:0] group_idx,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    // The memory has exactly 10 weight and 10 bias ports, so the lane count is fixed.
    localparam int LANES = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_BIAS,
        S_STREAM,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;

    // Configuration latched at start
    logic [AW-1:0] x_base_q,  x_base_d;
    logic [AW-1:0] w_base_q,  w_base_d;
    logic [AW-1:0] b_base_q,  b_base_d;
    logic [AW-1:0] in_len_q,  in_len_d;
    logic [AW-1:0] out_len_q, out_len_d;
    logic          err_q,     err_d;

    // Walk state: per-lane weight row pointers, first neuron of the group,
    // group counter and input index inside the group
    logic [AW-1:0] row_q [LANES];
    logic [AW-1:0] row_d [LANES];
    logic [AW-1:0] nbase_q, nbase_d;
    logic [AW-1:0] group_q, group_d;
    logic [AW-1:0] i_q,     i_d;

    // Read tags delayed by one cycle to line up with the registered read data
    logic          bias_valid_q, bias_valid_d;
    logic          data_valid_q, data_valid_d;
    logic          last_valid_q, last_valid_d;

    logic [AW-1:0] w_addr [LANES];
    logic [AW-1:0] b_addr [LANES];
    logic [AW-1:0] lane_stride;
    logic          last_beat;
    logic          group_end;

    // Moving to the next group advances every lane by LANES rows (truncated)
    assign lane_stride = in_len_q * AW'(LANES);
    assign last_beat   = (i_q == (in_len_q - AW'(1)));
    // One extra bit keeps the end-of-layer test correct for out_len near 2^AW
    assign group_end   = (({1'b0, nbase_q} + (AW+1)'(LANES)) >= {1'b0, out_len_q});

    // State register with synchronous active-low reset
    always_ff @(posedge clock_mem) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
        if (!rst) begin
            state_q      <= S_IDLE;
            x_base_q     <= '0;
            w_base_q     <= '0;
            b_base_q     <= '0;
            in_len_q     <= '0;
            out_len_q    <= '0;
            err_q        <= 1'b0;
            nbase_q      <= '0;
            group_q      <= '0;
            i_q          <= '0;
            bias_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
            last_valid_q <= 1'b0;
            // NOTE: the 10-entry row table is small, so it is cleared with the rest of the state; a real RAM array would not be.
            for (int k = 0; k < LANES; k++) begin
                row_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            x_base_q     <= x_base_d;
            w_base_q     <= w_base_d;
            b_base_q     <= b_base_d;
            in_len_q     <= in_len_d;
            out_len_q    <= out_len_d;
            err_q        <= err_d;
            nbase_q      <= nbase_d;
            group_q      <= group_d;
            i_q          <= i_d;
            bias_valid_q <= bias_valid_d;
            data_valid_q <= data_valid_d;
            last_valid_q <= last_valid_d;
            for (int k = 0; k < LANES; k++) begin
                row_q[k] <= row_d[k];
            end
        end
    end

    // Next-state logic, read enable and read tags
    always_comb begin
        // NOTE: every signal written here is defaulted first so no branch can infer a latch.
        state_d      = state_q;
        x_base_d     = x_base_q;
        w_base_d     = w_base_q;
        b_base_d     = b_base_q;
        in_len_d     = in_len_q;
        out_len_d    = out_len_q;
        err_d        = err_q;
        nbase_d      = nbase_q;
        group_d      = group_q;
        i_d          = i_q;
        bias_valid_d = 1'b0;
        data_valid_d = 1'b0;
        last_valid_d = 1'b0;
        mem_rd_en    = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            row_d[k] = row_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_base_d  = cfg_x_base;
                    w_base_d  = cfg_w_base;
                    b_base_d  = cfg_b_base;
                    in_len_d  = cfg_in_len;
                    out_len_d = cfg_out_len;
                    nbase_d   = '0;
                    group_d   = '0;
                    i_d       = '0;
                    if ((cfg_in_len == '0) || (cfg_out_len == '0)) begin
                        // Empty layer: report it and finish without touching memory
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_INIT;
                    end
                end
            end

            S_INIT: begin
                for (int k = 0; k < LANES; k++) begin
                    row_d[k] = w_base_q + in_len_q * AW'(k);
                end
                nbase_d = '0;
                group_d = '0;
                i_d     = '0;
                state_d = S_BIAS;
            end

            S_BIAS: begin
                if (acc_ready) begin
                    mem_rd_en    = 1'b1;
                    bias_valid_d = 1'b1;
                    state_d      = S_STREAM;
                end
            end

            S_STREAM: begin
                // A stall freezes i, so the addresses hold until the read is issued
                if (acc_ready) begin
                    mem_rd_en    = 1'b1;
                    data_valid_d = 1'b1;
                    if (last_beat) begin
                        last_valid_d = 1'b1;
                        state_d      = S_NEXT;
                    end else begin
                        i_d = i_q + AW'(1);
                    end
                end
            end

            S_NEXT: begin
                for (int k = 0; k < LANES; k++) begin
                    row_d[k] = row_q[k] + lane_stride;
                end
                nbase_d = nbase_q + AW'(LANES);
                group_d = group_q + AW'(1);
                i_d     = '0;
                state_d = group_end ? S_DONE : S_BIAS;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address pointers, driven only in the state that reads through them
    always_comb begin
        x_addr = '0;
        for (int k = 0; k < LANES; k++) begin
            w_addr[k] = '0;
            b_addr[k] = '0;
        end
        if (state_q == S_BIAS) begin
            for (int k = 0; k < LANES; k++) begin
                b_addr[k] = b_base_q + nbase_q + AW'(k);
            end
        end
        if (state_q == S_STREAM) begin
            x_addr = x_base_q + i_q;
            for (int k = 0; k < LANES; k++) begin
                w_addr[k] = row_q[k] + i_q;
            end
        end
    end

    // Lane k carries a real neuron while nbase + k is still inside the layer
    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_mask[k] = (({1'b0, nbase_q} + (AW+1)'(k)) < {1'b0, out_len_q});
        end
    end

    assign w1_addr  = w_addr[0];
    assign w2_addr  = w_addr[1];
    assign w3_addr  = w_addr[2];
    assign w4_addr  = w_addr[3];
    assign w5_addr  = w_addr[4];
    assign w6_addr  = w_addr[5];
    assign w7_addr  = w_addr[6];
    assign w8_addr  = w_addr[7];
    assign w9_addr  = w_addr[8];
    assign w10_addr = w_addr[9];

    assign b1_addr  = b_addr[0];
    assign b2_addr  = b_addr[1];
    assign b3_addr  = b_addr[2];
    assign b4_addr  = b_addr[3];
    assign b5_addr  = b_addr[4];
    assign b6_addr  = b_addr[5];
    assign b7_addr  = b_addr[6];
    assign b8_addr  = b_addr[7];
    assign b9_addr  = b_addr[8];
    assign b10_addr = b_addr[9];

    assign bias_valid = bias_valid_q;
    assign data_valid = data_valid_q;
    assign last_valid = last_valid_q;
    assign group_idx  = group_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign cfg_err    = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_mem_fetch_sequencer.sv
// Self-checking bench for mem_fetch_sequencer. A transaction-level model turns
// a layer configuration and an acc_ready pattern into the expected per-cycle
// read schedule, addresses, tags and done timing.

module tb_mem_fetch_sequencer;

    localparam int AW   = 16;
    localparam int MAXC = 1024;

    typedef struct packed {
        logic                rd;
        logic [1:0]          kind;   // 0 none, 1 bias read pending, 2 stream read pending
        logic [AW-1:0]       bbase;
        logic [AW-1:0]       x;
        logic [9:0][AW-1:0]  w;
        logic [9:0]          mask;
        logic [AW-1:0]       grp;
    } cyc_t;

    logic                clk;
    logic                rst;
    logic                start;
    logic [AW-1:0]       cfg_x_base, cfg_w_base, cfg_b_base, cfg_in_len, cfg_out_len;
    logic                acc_ready;
    logic                mem_rd_en;
    logic [AW-1:0]       x_addr;
    logic [9:0][AW-1:0]  w_o;
    logic [9:0][AW-1:0]  b_o;
    logic                bias_valid, data_valid, last_valid;
    logic [9:0]          lane_mask;
    logic [AW-1:0]       group_idx;
    logic                busy, done, cfg_err;

    cyc_t  exp_c [MAXC];
    logic  ev_b  [MAXC];
    logic  ev_d  [MAXC];
    logic  ev_l  [MAXC];
    logic  rdy   [MAXC];
    logic  exp_err;
    int    exp_dc;
    int    checks   = 0;
    int    failures = 0;
    string cur_name;

    mem_fetch_sequencer #(.AW(AW)) dut (
        .clock_mem   (clk),
        .rst         (rst),
        .start       (start),
        .cfg_x_base  (cfg_x_base),
        .cfg_w_base  (cfg_w_base),
        .cfg_b_base  (cfg_b_base),
        .cfg_in_len  (cfg_in_len),
        .cfg_out_len (cfg_out_len),
        .acc_ready   (acc_ready),
        .mem_rd_en   (mem_rd_en),
        .x_addr      (x_addr),
        .w1_addr     (w_o[0]),
        .w2_addr     (w_o[1]),
        .w3_addr     (w_o[2]),
        .w4_addr     (w_o[3]),
        .w5_addr     (w_o[4]),
        .w6_addr     (w_o[5]),
        .w7_addr     (w_o[6]),
        .w8_addr     (w_o[7]),
        .w9_addr     (w_o[8]),
        .w10_addr    (w_o[9]),
        .b1_addr     (b_o[0]),
        .b2_addr     (b_o[1]),
        .b3_addr     (b_o[2]),
        .b4_addr     (b_o[3]),
        .b5_addr     (b_o[4]),
        .b6_addr     (b_o[5]),
        .b7_addr     (b_o[6]),
        .b8_addr     (b_o[7]),
        .b9_addr     (b_o[8]),
        .b10_addr    (b_o[9]),
        .bias_valid  (bias_valid),
        .data_valid  (data_valid),
        .last_valid  (last_valid),
        .lane_mask   (lane_mask),
        .group_idx   (group_idx),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // acc_ready pattern: pct_low percent random low cycles plus an optional forced stall window
    task automatic fill_ready(input int pct_low, input int stall_from, input int stall_len);
        for (int c = 0; c < MAXC; c++) begin
            rdy[c] = ($urandom_range(99) >= pct_low);
            if (c >= stall_from && c < stall_from + stall_len) rdy[c] = 1'b0;
        end
    endtask

    // Reference schedule: start at cycle 0, INIT at 1, reads in order from cycle 2,
    // each read waits for acc_ready, one idle cycle after each group, then done.
    task automatic build_model(input int xb, input int wb, input int bb, input int il, input int ol);
        int   t;
        int   groups;
        int   nb;
        cyc_t e;
        logic [9:0]         m;
        logic [9:0][AW-1:0] rows;
        for (int c = 0; c < MAXC; c++) begin
            exp_c[c] = '0;
            ev_b[c]  = 1'b0;
            ev_d[c]  = 1'b0;
            ev_l[c]  = 1'b0;
        end
        exp_err = 1'b0;
        if (il == 0 || ol == 0) begin
            exp_err = 1'b1;
            exp_dc  = 1;
            return;
        end
        groups = (ol + 9) / 10;
        t = 2;
        for (int g = 0; g < groups; g++) begin
            nb = g * 10;
            for (int k = 0; k < 10; k++) begin
                m[k]    = ((nb + k) < ol);
                rows[k] = AW'(wb + (nb + k) * il);
            end
            e       = '0;
            e.kind  = 2'd1;
            e.bbase = AW'(bb + nb);
            e.mask  = m;
            e.grp   = AW'(g);
            while (!rdy[t] && t < MAXC - 64) begin
                exp_c[t] = e;
                t++;
            end
            e.rd = 1'b1;
            exp_c[t] = e;
            ev_b[t+1] = 1'b1;
            t++;
            for (int i = 0; i < il; i++) begin
                e      = '0;
                e.kind = 2'd2;
                e.x    = AW'(xb + i);
                for (int k = 0; k < 10; k++) e.w[k] = AW'(int'(rows[k]) + i);
                e.mask = m;
                e.grp  = AW'(g);
                while (!rdy[t] && t < MAXC - 64) begin
                    exp_c[t] = e;
                    t++;
                end
                e.rd = 1'b1;
                exp_c[t] = e;
                ev_d[t+1] = 1'b1;
                if (i == il - 1) ev_l[t+1] = 1'b1;
                t++;
            end
            t++;
        end
        exp_dc = t;
    endtask

    task automatic check_cycle(input int c);
        cyc_t e;
        string p;
        e = exp_c[c];
        p = $sformatf("%s c%0d", cur_name, c);
        check({p, " busy"},       busy,       32'(c <= exp_dc));
        check({p, " done"},       done,       32'(c == exp_dc));
        check({p, " cfg_err"},    cfg_err,    32'((c == exp_dc) && exp_err));
        check({p, " mem_rd_en"},  mem_rd_en,  32'(e.rd));
        check({p, " bias_valid"}, bias_valid, 32'(ev_b[c]));
        check({p, " data_valid"}, data_valid, 32'(ev_d[c]));
        check({p, " last_valid"}, last_valid, 32'(ev_l[c]));
        if (e.kind == 2'd1) begin
            for (int k = 0; k < 10; k++) begin
                check($sformatf("%s b%0d_addr", p, k + 1), b_o[k], 32'(AW'(e.bbase + AW'(k))));
            end
        end
        if (e.kind == 2'd2) begin
            check({p, " x_addr"}, x_addr, 32'(e.x));
            for (int k = 0; k < 10; k++) begin
                check($sformatf("%s w%0d_addr", p, k + 1), w_o[k], 32'(e.w[k]));
            end
        end
        if (e.kind != 2'd0) begin
            check({p, " lane_mask"}, lane_mask, 32'(e.mask));
            check({p, " group_idx"}, group_idx, 32'(e.grp));
        end
    endtask

    task automatic run_layer(input string name, input int xb, input int wb, input int bb,
                             input int il, input int ol, input int restart_cycle, input int spec_done);
        cur_name = name;
        build_model(xb, wb, bb, il, ol);
        @(negedge clk);
        cfg_x_base  = AW'(xb);
        cfg_w_base  = AW'(wb);
        cfg_b_base  = AW'(bb);
        cfg_in_len  = AW'(il);
        cfg_out_len = AW'(ol);
        start       = 1'b1;
        acc_ready   = rdy[0];
        for (int c = 1; c <= exp_dc + 1; c++) begin
            @(negedge clk);
            start     = (c == restart_cycle);
            acc_ready = rdy[c];
            #1;
            check_cycle(c);
            if (c == spec_done) check({name, " done_at_spec_cycle"}, done, 32'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_rd_en"},  mem_rd_en,  32'd0);
        check({tag, " x_addr"},     x_addr,     32'd0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("%s w%0d_addr", tag, k + 1), w_o[k], 32'd0);
            check($sformatf("%s b%0d_addr", tag, k + 1), b_o[k], 32'd0);
        end
        check({tag, " bias_valid"}, bias_valid, 32'd0);
        check({tag, " data_valid"}, data_valid, 32'd0);
        check({tag, " last_valid"}, last_valid, 32'd0);
        check({tag, " lane_mask"},  lane_mask,  32'd0);
        check({tag, " group_idx"},  group_idx,  32'd0);
        check({tag, " busy"},       busy,       32'd0);
        check({tag, " done"},       done,       32'd0);
        check({tag, " cfg_err"},    cfg_err,    32'd0);
    endtask

    initial begin
        int xb, wb, bb, il, ol;

        // Reset state
        rst = 1'b0; start = 1'b0; acc_ready = 1'b1;
        cfg_x_base = '0; cfg_w_base = '0; cfg_b_base = '0; cfg_in_len = '0; cfg_out_len = '0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Single group, no stalls
        fill_ready(0, -1, 0);
        run_layer("single", 16'h0000, 16'h0100, 16'h0080, 4, 10, -1, 8);

        // Partial final group
        fill_ready(0, -1, 0);
        run_layer("partial", 16'h0040, 16'h0200, 16'h0300, 2, 13, -1, 10);

        // Three-cycle stall after the second stream read
        fill_ready(0, 5, 3);
        run_layer("stall", 16'h0000, 16'h0100, 16'h0080, 4, 10, -1, 11);

        // Reset while streaming at i=2
        fill_ready(0, -1, 0);
        @(negedge clk);
        cfg_x_base = 16'h0010; cfg_w_base = 16'h0100; cfg_b_base = 16'h0080;
        cfg_in_len = 16'd4;    cfg_out_len = 16'd10;
        start = 1'b1; acc_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
        end
        check("rst_mid x_addr_before", x_addr, 32'h0012);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("rst_mid after data_valid", data_valid, 32'd0);
            check("rst_mid after mem_rd_en",  mem_rd_en,  32'd0);
            check("rst_mid after busy",       busy,       32'd0);
        end
        run_layer("after_rst", 16'h0000, 16'h0100, 16'h0080, 4, 10, -1, 8);

        // Rejected configurations
        fill_ready(0, -1, 0);
        run_layer("bad_in_len",  16'h0000, 16'h0100, 16'h0080, 0, 10, -1, 1);
        run_layer("bad_out_len", 16'h0000, 16'h0100, 16'h0080, 4, 0,  -1, 1);

        // Second start during BIAS is ignored
        run_layer("busy_start", 16'h0000, 16'h0100, 16'h0080, 4, 10, 2, 8);

        // Weight pointer wraps past the top of the address space
        run_layer("wrap", 16'h0000, 16'hFFFE, 16'h0080, 4, 10, -1, 8);

        // Randomized layers with random back-pressure
        for (int r = 0; r < 6; r++) begin
            xb = int'($urandom_range(16'hFFFF));
            wb = int'($urandom_range(16'hFFFF));
            bb = int'($urandom_range(16'hFFFF));
            il = int'($urandom_range(6, 1));
            ol = int'($urandom_range(35, 1));
            fill_ready(25, -1, 0);
            run_layer($sformatf("rand%0d", r), xb, wb, bb, il, ol, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
